// File: rtl/spi_trans_sequencer.sv
// Sequences one multi-word SPI transaction: SS setup, per-word TX pop / shift / optional RX push, SS hold, done.
// Optional stall watchdog is compiled in when SPI_SEQ_TIMEOUT_EN is defined.
module spi_trans_sequencer #(
  parameter int DATA_W   = 32,
  parameter int LEN_W    = 8,
  parameter int SS_W     = 4,
  parameter int SS_SETUP = 2,
  parameter int SS_HOLD  = 2,
  parameter int TIMEOUT  = 1024
) (
  input  logic              clk_i,
  input  logic              reset_n_i,
  input  logic              trans_start_i,
  input  logic [LEN_W-1:0]  trans_len_i,
  input  logic [SS_W-1:0]   trans_ss_i,
  input  logic              trans_rx_en_i,
  input  logic              abort_i,
  output logic              busy_o,
  output logic              trans_done_o,
  output logic [1:0]        err_o,
  input  logic              tx_empty_i,
  input  logic [DATA_W-1:0] tx_data_i,
  output logic              tx_pull_o,
  input  logic              rx_full_i,
  output logic [DATA_W-1:0] rx_data_o,
  output logic              rx_push_o,
  output logic              sh_start_o,
  output logic [DATA_W-1:0] sh_data_o,
  input  logic              sh_done_i,
  input  logic [DATA_W-1:0] sh_data_i,
  output logic [SS_W-1:0]   ss_n_o
);

  localparam int CNT_MAX = (SS_SETUP > SS_HOLD) ? SS_SETUP : SS_HOLD;
  localparam int CNT_W   = (CNT_MAX < 2) ? 1 : $clog2(CNT_MAX);
  // The LOAD cycle itself is the last setup cycle, so SETUP lasts SS_SETUP-1 cycles.
  localparam logic [CNT_W-1:0] SETUP_LAST = CNT_W'((SS_SETUP > 1) ? SS_SETUP - 2 : 0);
  localparam logic [CNT_W-1:0] HOLD_LAST  = CNT_W'(SS_HOLD - 1);

  localparam logic [1:0] ERR_OK      = 2'd0;
  localparam logic [1:0] ERR_ABORT   = 2'd1;
  localparam logic [1:0] ERR_TIMEOUT = 2'd2;

  typedef enum logic [2:0] {
    IDLE, SETUP, LOAD, SHIFT, STORE, NEXT, HOLD
  } state_t;

  state_t             state_reg;
  logic [LEN_W-1:0]   rem_reg;
  logic [CNT_W-1:0]   cnt_reg;
  logic               rx_en_reg;
  logic               abort_pend_reg;
  logic               timeout_hit;

`ifdef SPI_SEQ_TIMEOUT_EN
  localparam int WD_W = $clog2(TIMEOUT + 1);

  logic [WD_W-1:0] wd_cnt_reg;
  logic            stall;

  always_comb begin
    stall = 1'b0;
    case (state_reg)
      LOAD:    stall = tx_empty_i;
      SHIFT:   stall = !sh_done_i;
      STORE:   stall = rx_full_i;
      default: stall = 1'b0;
    endcase
  end

  // Any non-stalled cycle in these states is a state change, so clearing on !stall restarts the count.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      wd_cnt_reg <= '0;
    end else if (stall) begin
      wd_cnt_reg <= wd_cnt_reg + WD_W'(1);
    end else begin
      wd_cnt_reg <= '0;
    end
  end

  assign timeout_hit = stall && (wd_cnt_reg == WD_W'(TIMEOUT - 1));
`else
  // Watchdog absent: stalls wait indefinitely.
  assign timeout_hit = 1'b0 & (TIMEOUT != 0);
`endif

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_reg      <= IDLE;
      rem_reg        <= '0;
      cnt_reg        <= '0;
      rx_en_reg      <= 1'b0;
      abort_pend_reg <= 1'b0;
      ss_n_o         <= '1;
      busy_o         <= 1'b0;
      trans_done_o   <= 1'b0;
      err_o          <= ERR_OK;
      tx_pull_o      <= 1'b0;
      rx_push_o      <= 1'b0;
      sh_start_o     <= 1'b0;
      rx_data_o      <= '0;
      sh_data_o      <= '0;
    end else begin
      tx_pull_o    <= 1'b0;
      rx_push_o    <= 1'b0;
      sh_start_o   <= 1'b0;
      trans_done_o <= 1'b0;

      case (state_reg)
        IDLE: begin
          if (trans_start_i) begin
            err_o <= ERR_OK;
            if (trans_len_i == '0) begin
              trans_done_o <= 1'b1;
            end else begin
              rem_reg        <= trans_len_i;
              rx_en_reg      <= trans_rx_en_i;
              abort_pend_reg <= 1'b0;
              cnt_reg        <= '0;
              ss_n_o         <= ~trans_ss_i;
              busy_o         <= 1'b1;
              state_reg      <= (SS_SETUP > 1) ? SETUP : LOAD;
            end
          end
        end

        SETUP: begin
          if (abort_i) begin
            err_o     <= ERR_ABORT;
            cnt_reg   <= '0;
            state_reg <= HOLD;
          end else if (cnt_reg == SETUP_LAST) begin
            cnt_reg   <= '0;
            state_reg <= LOAD;
          end else begin
            cnt_reg <= cnt_reg + CNT_W'(1);
          end
        end

        LOAD: begin
          if (abort_i) begin
            err_o     <= ERR_ABORT;
            cnt_reg   <= '0;
            state_reg <= HOLD;
          end else if (timeout_hit) begin
            err_o     <= ERR_TIMEOUT;
            cnt_reg   <= '0;
            state_reg <= HOLD;
          end else if (!tx_empty_i) begin
            tx_pull_o  <= 1'b1;
            sh_data_o  <= tx_data_i;
            sh_start_o <= 1'b1;
            state_reg  <= SHIFT;
          end
        end

        // The engine is never cut mid-word; an abort is remembered until it reports done.
        SHIFT: begin
          if (sh_done_i) begin
            if (abort_pend_reg || abort_i) begin
              err_o     <= ERR_ABORT;
              cnt_reg   <= '0;
              state_reg <= HOLD;
            end else begin
              rx_data_o <= sh_data_i;
              state_reg <= rx_en_reg ? STORE : NEXT;
            end
          end else if (timeout_hit) begin
            err_o     <= (abort_pend_reg || abort_i) ? ERR_ABORT : ERR_TIMEOUT;
            cnt_reg   <= '0;
            state_reg <= HOLD;
          end else if (abort_i) begin
            abort_pend_reg <= 1'b1;
          end
        end

        STORE: begin
          if (abort_i) begin
            err_o     <= ERR_ABORT;
            cnt_reg   <= '0;
            state_reg <= HOLD;
          end else if (timeout_hit) begin
            err_o     <= ERR_TIMEOUT;
            cnt_reg   <= '0;
            state_reg <= HOLD;
          end else if (!rx_full_i) begin
            rx_push_o <= 1'b1;
            state_reg <= NEXT;
          end
        end

        NEXT: begin
          if (abort_i) begin
            err_o     <= ERR_ABORT;
            cnt_reg   <= '0;
            state_reg <= HOLD;
          end else if (rem_reg == LEN_W'(1)) begin
            cnt_reg   <= '0;
            state_reg <= HOLD;
          end else begin
            rem_reg   <= rem_reg - LEN_W'(1);
            state_reg <= LOAD;
          end
        end

        HOLD: begin
          if (cnt_reg == HOLD_LAST) begin
            ss_n_o       <= '1;
            busy_o       <= 1'b0;
            trans_done_o <= 1'b1;
            cnt_reg      <= '0;
            state_reg    <= IDLE;
          end else begin
            cnt_reg <= cnt_reg + CNT_W'(1);
          end
        end

        default: state_reg <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_spi_trans_sequencer.sv
// Directed bench for spi_trans_sequencer: FIFO and shift-engine models, event timestamps, hand-computed expectations.
// The watchdog case runs only when SPI_SEQ_TIMEOUT_EN is defined.
module tb_spi_trans_sequencer;

  localparam int DATA_W   = 32;
  localparam int LEN_W    = 8;
  localparam int SS_W     = 4;
  localparam int SS_SETUP = 2;
  localparam int SS_HOLD  = 2;
  localparam int TIMEOUT  = 16;

  logic              clk_i = 1'b0;
  logic              reset_n_i = 1'b0;
  logic              trans_start_i = 1'b0;
  logic [LEN_W-1:0]  trans_len_i = '0;
  logic [SS_W-1:0]   trans_ss_i = '0;
  logic              trans_rx_en_i = 1'b0;
  logic              abort_i = 1'b0;
  logic              busy_o;
  logic              trans_done_o;
  logic [1:0]        err_o;
  logic              tx_empty_i;
  logic [DATA_W-1:0] tx_data_i;
  logic              tx_pull_o;
  logic              rx_full_i = 1'b0;
  logic [DATA_W-1:0] rx_data_o;
  logic              rx_push_o;
  logic              sh_start_o;
  logic [DATA_W-1:0] sh_data_o;
  logic              sh_done_i = 1'b0;
  logic [DATA_W-1:0] sh_data_i = '0;
  logic [SS_W-1:0]   ss_n_o;

  spi_trans_sequencer #(
    .DATA_W(DATA_W), .LEN_W(LEN_W), .SS_W(SS_W),
    .SS_SETUP(SS_SETUP), .SS_HOLD(SS_HOLD), .TIMEOUT(TIMEOUT)
  ) dut (
    .clk_i(clk_i), .reset_n_i(reset_n_i),
    .trans_start_i(trans_start_i), .trans_len_i(trans_len_i), .trans_ss_i(trans_ss_i),
    .trans_rx_en_i(trans_rx_en_i), .abort_i(abort_i),
    .busy_o(busy_o), .trans_done_o(trans_done_o), .err_o(err_o),
    .tx_empty_i(tx_empty_i), .tx_data_i(tx_data_i), .tx_pull_o(tx_pull_o),
    .rx_full_i(rx_full_i), .rx_data_o(rx_data_o), .rx_push_o(rx_push_o),
    .sh_start_o(sh_start_o), .sh_data_o(sh_data_o), .sh_done_i(sh_done_i), .sh_data_i(sh_data_i),
    .ss_n_o(ss_n_o)
  );

  always #5 clk_i = ~clk_i;

  int cyc = 0;
  always @(posedge clk_i) cyc <= cyc + 1;

  // TX FIFO model (first-word-fall-through)
  logic [DATA_W-1:0] tx_mem [0:63];
  int tx_rd = 0;
  int tx_wr = 0;
  assign tx_empty_i = (tx_rd == tx_wr);
  assign tx_data_i  = tx_mem[tx_rd % 64];

  // Monitor state
  int n_pull = 0, n_start = 0, n_push = 0, n_done = 0, n_shdone = 0, order_err = 0;
  int t_ss_fall = 0, t_ss_rise = 0, t_start_last = 0, t_done = 0, t_shdone = 0;
  int push_t [0:63];
  logic [DATA_W-1:0] rx_w [0:63];
  logic [DATA_W-1:0] sh_w [0:63];
  logic [1:0] last_err = '0;
  logic [SS_W-1:0] ss_val = '1;
  logic ss_low = 1'b0;
  int eng_cnt = 0;
  logic [DATA_W-1:0] eng_word = '0;

  // Stimulus-side state
  int n_vec = 0, n_miss = 0;
  int b_start, b_pull, b_push, b_done, b_shdone, b_order;
  int start_base = 0, push_base = 0;
  logic rx_en_mode = 1'b0;
  int t_start = 0, t_full_low = 0, t_abort = 0;

  // Shift engine echoes word+1 eight cycles after sh_start_o; all DUT outputs are sampled here.
  always @(negedge clk_i) begin
    sh_done_i = 1'b0;
    if (eng_cnt > 0) begin
      eng_cnt = eng_cnt - 1;
      if (eng_cnt == 0) begin
        sh_done_i = 1'b1;
        sh_data_i = eng_word + 1;
        t_shdone  = cyc;
        n_shdone  = n_shdone + 1;
      end
    end
    if (sh_start_o) begin
      sh_w[n_start % 64] = sh_data_o;
      n_start = n_start + 1;
      t_start_last = cyc;
      if (rx_en_mode && (n_push - push_base) != (n_start - start_base) - 1) order_err = order_err + 1;
      eng_cnt  = 8;
      eng_word = sh_data_o;
    end
    if (tx_pull_o) begin
      n_pull = n_pull + 1;
      tx_rd  = tx_rd + 1;
    end
    if (rx_push_o) begin
      rx_w[n_push % 64]   = rx_data_o;
      push_t[n_push % 64] = cyc;
      n_push = n_push + 1;
    end
    if (trans_done_o) begin
      n_done   = n_done + 1;
      last_err = err_o;
      t_done   = cyc;
    end
    if (ss_n_o != '1 && !ss_low) begin
      ss_low = 1'b1; t_ss_fall = cyc; ss_val = ss_n_o;
    end else if (ss_n_o == '1 && ss_low) begin
      ss_low = 1'b0; t_ss_rise = cyc;
    end
  end

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec = n_vec + 1;
    if (got !== exp) begin
      n_miss = n_miss + 1;
      $display("FAIL %s: got 0x%0h, want 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk_i);
    #1;
  endtask

  task automatic push_tx(input logic [DATA_W-1:0] w);
    tx_mem[tx_wr % 64] = w;
    tx_wr = tx_wr + 1;
  endtask

  task automatic snap();
    b_start = n_start; b_pull = n_pull; b_push = n_push;
    b_done = n_done; b_shdone = n_shdone; b_order = order_err;
  endtask

  task automatic start(input int len, input logic [SS_W-1:0] ss, input logic rx_en);
    trans_len_i   = LEN_W'(len);
    trans_ss_i    = ss;
    trans_rx_en_i = rx_en;
    rx_en_mode    = rx_en;
    start_base    = n_start;
    push_base     = n_push;
    trans_start_i = 1'b1;
    t_start       = cyc;
    tick();
    trans_start_i = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int budget);
    int k = 0;
    while (n_done == b_done && k < budget) begin
      tick();
      k++;
    end
    check_eq(tag, 64'(n_done - b_done), 64'd1);
  endtask

  task automatic wait_starts(input string tag, input int cnt, input int budget);
    int k = 0;
    while (n_start - b_start < cnt && k < budget) begin
      tick();
      k++;
    end
    check_eq(tag, 64'(n_start - b_start), 64'(cnt));
  endtask

  initial begin
    int k;
    repeat (3) tick();
    check_eq("rst_ss_n", ss_n_o, 4'hF);
    check_eq("rst_busy_err", {busy_o, err_o}, 3'b000);
    check_eq("rst_pulses", {tx_pull_o, rx_push_o, sh_start_o, trans_done_o}, 4'b0000);
    check_eq("rst_data", {rx_data_o, sh_data_o}, 64'd0);
    reset_n_i = 1'b1;
    tick();

    // T1: single word, echo +1, exact SS setup/hold
    push_tx(32'hA5A5_0001);
    snap();
    start(1, 4'b0010, 1'b1);
    wait_done("t1_done", 200);
    check_eq("t1_ss_sel", ss_val, 4'b1101);
    check_eq("t1_setup_cycles", 64'(t_start_last - t_ss_fall), 64'(SS_SETUP));
    check_eq("t1_pops", 64'(n_pull - b_pull), 64'd1);
    check_eq("t1_starts", 64'(n_start - b_start), 64'd1);
    check_eq("t1_pushes", 64'(n_push - b_push), 64'd1);
    check_eq("t1_rx_word", rx_w[b_push % 64], 32'hA5A5_0002);
    check_eq("t1_err", last_err, 2'd0);
    check_eq("t1_hold_cycles", 64'(t_ss_rise - push_t[b_push % 64]), 64'(SS_HOLD + 1));
    check_eq("t1_done_at_release", 64'(t_done), 64'(t_ss_rise));
    check_eq("t1_idle_after", {busy_o, ss_n_o}, 5'b0_1111);

    // T2: three words, TX empty for 20 cycles, no RX storage
    snap();
    start(3, 4'b0001, 1'b0);
    repeat (20) tick();
    check_eq("t2_busy_stalled", busy_o, 1'b1);
    check_eq("t2_no_start_empty", 64'(n_start - b_start), 64'd0);
    push_tx(32'h0000_0011);
    push_tx(32'h0000_0022);
    push_tx(32'h0000_0033);
    wait_done("t2_done", 300);
    check_eq("t2_starts", 64'(n_start - b_start), 64'd3);
    check_eq("t2_pops", 64'(n_pull - b_pull), 64'd3);
    check_eq("t2_pushes", 64'(n_push - b_push), 64'd0);
    check_eq("t2_word0", sh_w[b_start % 64], 32'h0000_0011);
    check_eq("t2_word2", sh_w[(b_start + 2) % 64], 32'h0000_0033);
    check_eq("t2_err", last_err, 2'd0);

    // T3: RX full for 10 cycles after word 1
    push_tx(32'h1000_0000);
    push_tx(32'h2000_0000);
    snap();
    start(2, 4'b0100, 1'b1);
    rx_full_i = 1'b1;
    k = 0;
    while (n_shdone == b_shdone && k < 100) begin
      tick();
      k++;
    end
    check_eq("t3_word1_shifted", 64'(n_shdone - b_shdone), 64'd1);
    repeat (10) tick();
    check_eq("t3_no_push_full", 64'(n_push - b_push), 64'd0);
    check_eq("t3_no_2nd_start", 64'(n_start - b_start), 64'd1);
    rx_full_i  = 1'b0;
    t_full_low = cyc;
    wait_done("t3_done", 200);
    check_eq("t3_push_after_full", 64'(push_t[b_push % 64]), 64'(t_full_low + 1));
    check_eq("t3_rx_word0", rx_w[b_push % 64], 32'h1000_0001);
    check_eq("t3_rx_word1", rx_w[(b_push + 1) % 64], 32'h2000_0001);
    check_eq("t3_order", 64'(order_err - b_order), 64'd0);
    check_eq("t3_err", last_err, 2'd0);

    // T4: abort during SHIFT of word 2 of 4
    push_tx(32'h0000_0101);
    push_tx(32'h0000_0202);
    push_tx(32'h0000_0303);
    push_tx(32'h0000_0404);
    snap();
    start(4, 4'b1000, 1'b1);
    wait_starts("t4_reach_word2", 2, 200);
    repeat (3) tick();
    abort_i = 1'b1;
    t_abort = cyc;
    tick();
    abort_i = 1'b0;
    wait_done("t4_done", 200);
    check_eq("t4_err", last_err, 2'd1);
    check_eq("t4_starts", 64'(n_start - b_start), 64'd2);
    check_eq("t4_pops", 64'(n_pull - b_pull), 64'd2);
    check_eq("t4_pushes", 64'(n_push - b_push), 64'd1);
    check_eq("t4_engine_not_cut", t_shdone > t_abort, 1'b1);
    check_eq("t4_hold_cycles", 64'(t_ss_rise - t_shdone), 64'(SS_HOLD + 1));
    check_eq("t4_done_at_release", 64'(t_done), 64'(t_ss_rise));
    tx_wr = tx_rd;

    // T5: zero-length request, then start while busy
    snap();
    start(0, 4'b1111, 1'b0);
    check_eq("t5_len0_done", {trans_done_o, err_o}, 3'b100);
    check_eq("t5_len0_idle", {busy_o, ss_n_o}, 5'b0_1111);
    tick();
    check_eq("t5_done_1cyc", trans_done_o, 1'b0);
    check_eq("t5_len0_count", 64'(n_done - b_done), 64'd1);
    push_tx(32'h5555_AAAA);
    snap();
    start(1, 4'b0001, 1'b0);
    repeat (3) tick();
    trans_len_i   = '0;
    trans_start_i = 1'b1;
    tick();
    trans_start_i = 1'b0;
    check_eq("t5_busy_start_ignored", 64'(n_done - b_done), 64'd0);
    wait_done("t5_done", 200);
    repeat (5) tick();
    check_eq("t5_single_done", 64'(n_done - b_done), 64'd1);
    check_eq("t5_pops", 64'(n_pull - b_pull), 64'd1);

`ifdef SPI_SEQ_TIMEOUT_EN
    // T6: TX empty forever, watchdog fires after TIMEOUT LOAD cycles
    snap();
    start(1, 4'b0010, 1'b1);
    wait_done("t6_done", 100);
    check_eq("t6_err", last_err, 2'd2);
    check_eq("t6_latency", 64'(t_done - t_start), 64'(SS_SETUP - 1 + TIMEOUT + SS_HOLD + 1));
    check_eq("t6_pops", 64'(n_pull - b_pull), 64'd0);
`endif

    // Reset asserted mid-SHIFT
    push_tx(32'hDEAD_BEEF);
    snap();
    start(1, 4'b0100, 1'b1);
    wait_starts("rst_mid_started", 1, 100);
    repeat (2) tick();
    check_eq("rst_mid_busy_before", busy_o, 1'b1);
    reset_n_i = 1'b0;
    #1;
    check_eq("rst_mid_ss_n", ss_n_o, 4'hF);
    check_eq("rst_mid_busy_err", {busy_o, err_o}, 3'b000);
    check_eq("rst_mid_sh_data", sh_data_o, 32'd0);
    repeat (2) tick();
    reset_n_i = 1'b1;
    tx_wr = tx_rd;
    repeat (12) tick();
    check_eq("rst_mid_stays_idle", {busy_o, ss_n_o}, 5'b0_1111);
    check_eq("rst_mid_no_done", 64'(n_done - b_done), 64'd0);
    check_eq("rst_mid_no_restart", 64'(n_start - b_start), 64'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got hang, want finish");
    $fatal(1);
  end

endmodule
